counter_group_scheduler: RTL and testbench
==========================================

// Module: counter_group_scheduler
// PURPOSE
//  Time-division scheduler for the three 3-bit counter groups q[8:6] (G1), q[5:3] (G2), q[2:0] (G3).
//  A single shared tick prescaler is granted to one group at a time, round-robin G1->G2->G3->G1.
//  Each grant lasts DWELL_TICKS ticks; only the owner group counts.
//  Debounced active-low buttons start/pause/stop the schedule and preset all groups.
//  Sits between the board buttons and the LED/q pins.
// PARAMETERS
//  F_CLK_HZ     25_000_000  clock frequency (Hz)
//  TICK_MS      100         tick period (ms); TICK_CYC = max(1, F_CLK_HZ/1000*TICK_MS)
//  DWELL_TICKS  8           ticks per grant (>=1)
//  DEB_MS       20          debounce window (ms); DEB_CYC = max(1, F_CLK_HZ/1000*DEB_MS)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  async, active-low; 0 = reset
//  btn_start   in   1  active-low, async pin; press toggles RUN/PAUSE, starts from IDLE
//  btn_stop    in   1  active-low, async pin; press -> IDLE
//  btn_preset  in   1  active-low, async pin; press -> all groups = 3'b111
//  q           out  9  {G1,G2,G3} counter values
//  q_copy      out  6  mirror of q[5:0]
//  grp_en      out  3  one-hot owner: 100=G1, 010=G2, 001=G3; 000 in IDLE
//  state       out  2  00 IDLE, 01 RUN, 10 PAUSE (11 unused, decodes to IDLE)
//  led         out  1  1 only in RUN
// BEHAVIOUR
//  Reset (reset=0, async): q=0, state=IDLE, grp_en=000, led=0; prescaler, dwell count, owner=G1 cleared;
//   synchronizers and debounced levels forced to 1 (released), so no press event on release of reset.
//  Button path: 2-FF sync -> debouncer (level accepted after DEB_CYC consecutive equal samples) ->
//   press event = 1-cycle pulse on debounced 1->0. Pin-fall to event: DEB_CYC+2..DEB_CYC+3 cycles.
//   Glitches shorter than DEB_CYC cycles produce no event. Release generates no event.
//  Prescaler: counts 0..TICK_CYC-1, tick = (cnt==TICK_CYC-1) while in RUN; holds in PAUSE; cleared in IDLE.
//  Dwell: counts ticks 0..DWELL_TICKS-1; on the tick with dwell==DWELL_TICKS-1, owner advances
//   round-robin and dwell->0 (same cycle as the owner's last increment).
//  Counting: on tick in RUN, owner group <= group+1, modulo 8 (111 -> 000). Other groups hold.
//  FSM (events evaluated per cycle, priority stop > start):
//   IDLE  --start--> RUN   (owner=G1, dwell=0, prescaler=0; q retained)
//   RUN   --start--> PAUSE (prescaler, dwell, owner, q frozen)
//   PAUSE --start--> RUN   (resume exactly where frozen)
//   any   --stop --> IDLE  (owner=G1, dwell=0, prescaler=0; q retained)
//  Preset event: all three groups = 3'b111 in any state; state/owner/dwell/prescaler unaffected.
//   Preset and tick in same cycle: preset wins for q; dwell still advances.
//   Preset with stop in same cycle: both take effect.
//  State transitions, q, grp_en, led are registered: visible the cycle after the event/tick.
//  Reset asserted mid-RUN/PAUSE: immediate return to reset values, no clock edge required.
// TESTING (F_CLK_HZ=1000, TICK_MS=2 -> TICK_CYC=2, DEB_MS=3 -> DEB_CYC=3, DWELL_TICKS=2)
//  1. Reset, hold btn_start=0 10 cycles -> state=01, grp_en=100, led=1 within 6 cycles of pin fall; q=0.
//  2. Run 12 ticks -> q[8:6] 1,2 then q[5:3] 1,2 then q[2:0] 1,2, repeating; after 12 ticks q={3'd4,3'd4,3'd4}, grp_en=100.
//  3. Start press in RUN mid-dwell -> state=10, led=0, q unchanged for 100 cycles;
//     press again -> same owner resumes, finishes its remaining dwell.
//  4. Preset press in RUN with owner G2 -> q=9'h1FF, q_copy=6'h3F; next owner tick -> q[5:3]=000, others 111.
//  5. btn_stop 1-cycle/2-cycle low glitches -> no change; stop held 6 cycles -> state=00, grp_en=000, q retained.
//  6. reset=0 asynchronously mid-RUN (between clk edges) -> q=0, state=00, grp_en=000, led=0 before next edge.
//     No press event follows its release with buttons high.

Source files
------------

// File: rtl/counter_group_scheduler.sv
// rtl/counter_group_scheduler.sv - round-robin tick scheduler for three 3-bit counter groups
// One shared prescaler is granted to G1->G2->G3 for DWELL_TICKS ticks each; buttons start/pause/stop/preset.
module counter_group_scheduler #(
   parameter int F_CLK_HZ    = 25_000_000,
   parameter int TICK_MS     = 100,
   parameter int DWELL_TICKS = 8,
   parameter int DEB_MS      = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_stop,
   input  logic       btn_preset,
   output logic [8:0] q,
   output logic [5:0] q_copy,
   output logic [2:0] grp_en,
   output logic [1:0] state,
   output logic       led
);
   localparam int TICK_RAW = F_CLK_HZ / 1000 * TICK_MS;
   localparam int TICK_CYC = (TICK_RAW < 1) ? 1 : TICK_RAW;
   localparam int DEB_RAW  = F_CLK_HZ / 1000 * DEB_MS;
   localparam int DEB_CYC  = (DEB_RAW < 1) ? 1 : DEB_RAW;
   localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam int DWELL_W  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   logic [2:0]         btn_pin;
   logic [2:0]         sync_a;
   logic [2:0]         sync_b;
   logic [2:0]         deb_lvl;
   logic [2:0]         press;
   logic [DEB_W-1:0]   deb_cnt [3];
   state_t             st_q;
   state_t             st_d;
   logic [TICK_W-1:0]  presc;
   logic [DWELL_W-1:0] dwell;
   logic [1:0]         owner;
   logic               ev_start;
   logic               ev_stop;
   logic               ev_preset;
   logic               running;
   logic               active;
   logic               tick;
   logic               clear_sched;

   assign btn_pin = {btn_preset, btn_stop, btn_start};

   // Synchronizers and debounced levels reset to released so reset release never looks like a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a  <= '1;
         sync_b  <= '1;
         deb_lvl <= '1;
         press   <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         sync_a <= btn_pin;
         sync_b <= sync_a;
         for (int i = 0; i < 3; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
               deb_cnt[i] <= '0;
               deb_lvl[i] <= sync_b[i];
               press[i]   <= ~sync_b[i];
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign ev_start    = press[0];
   assign ev_stop     = press[1];
   assign ev_preset   = press[2];
   assign running     = (st_q == ST_RUN);
   assign active      = (st_q == ST_RUN) || (st_q == ST_PAUSE);
   // A start/stop event freezes the schedule on the very cycle it lands.
   assign tick        = running && !ev_start && !ev_stop && (presc == TICK_W'(TICK_CYC - 1));
   assign clear_sched = ev_stop || (!active && ev_start);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) st_q <= ST_IDLE;
      else        st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      case (st_q)
         ST_RUN:   st_d = ev_start ? ST_PAUSE : ST_RUN;
         ST_PAUSE: st_d = ev_start ? ST_RUN : ST_PAUSE;
         default:  st_d = ev_start ? ST_RUN : ST_IDLE;
      endcase
      if (ev_stop) st_d = ST_IDLE;
   end

   always_comb begin
      led    = running;
      state  = active ? st_q : ST_IDLE;
      grp_en = 3'b000;
      if (active) begin
         case (owner)
            2'd0:    grp_en = 3'b100;
            2'd1:    grp_en = 3'b010;
            default: grp_en = 3'b001;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
         dwell <= '0;
         owner <= 2'd0;
         q     <= '0;
      end else begin
         if (clear_sched) begin
            presc <= '0;
            dwell <= '0;
            owner <= 2'd0;
         end else if (running && !ev_start) begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
               if (dwell == DWELL_W'(DWELL_TICKS - 1)) begin
                  dwell <= '0;
                  owner <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
         end
         // Preset overrides the owner's increment; dwell bookkeeping above still proceeds.
         if (ev_preset) begin
            q <= '1;
         end else if (tick) begin
            case (owner)
               2'd0:    q[8:6] <= q[8:6] + 3'd1;
               2'd1:    q[5:3] <= q[5:3] + 3'd1;
               default: q[2:0] <= q[2:0] + 3'd1;
            endcase
         end
      end
   end

   assign q_copy = q[5:0];

endmodule

// File: tb/tb_counter_group_scheduler.sv
// tb/tb_counter_group_scheduler.sv - bench for counter_group_scheduler
// Reference model tracks schedule with plain integers and a sample-window debounce.
module tb_counter_group_scheduler;
   localparam int F_CLK_HZ    = 1000;
   localparam int TICK_MS     = 2;
   localparam int DEB_MS      = 3;
   localparam int DWELL_TICKS = 2;
   localparam int TICK_CYC    = 2;
   localparam int DEB_CYC     = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_start = 1'b1;
   logic       btn_stop = 1'b1;
   logic       btn_preset = 1'b1;
   logic [8:0] q;
   logic [5:0] q_copy;
   logic [2:0] grp_en;
   logic [1:0] state;
   logic       led;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   counter_group_scheduler #(
      .F_CLK_HZ(F_CLK_HZ), .TICK_MS(TICK_MS), .DWELL_TICKS(DWELL_TICKS), .DEB_MS(DEB_MS)
   ) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_stop(btn_stop),
      .btn_preset(btn_preset), .q(q), .q_copy(q_copy), .grp_en(grp_en),
      .state(state), .led(led)
   );

   // model: state 0 idle, 1 run, 2 pause; owner 0=G1
   int m_state, m_owner, m_dwell, m_presc, m_ticks, m_pre_cnt;
   int m_q [3];
   logic [DEB_CYC+1:0] h_start, h_stop, h_pre;
   logic l_start, l_stop, l_pre;
   logic e_start, e_stop, e_pre;

   task automatic deb_step(input logic [DEB_CYC+1:0] h, input logic lvl_in,
                           output logic lvl_out, output logic ev);
      logic [DEB_CYC-1:0] w;
      w = h[DEB_CYC+1:2];
      lvl_out = lvl_in;
      ev = 1'b0;
      if (lvl_in && w == '0) begin
         lvl_out = 1'b0;
         ev = 1'b1;
      end else if (!lvl_in && (&w)) begin
         lvl_out = 1'b1;
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state = 0; m_owner = 0; m_dwell = 0; m_presc = 0; m_ticks = 0;
         m_q = '{0, 0, 0};
         h_start = '1; h_stop = '1; h_pre = '1;
         l_start = 1'b1; l_stop = 1'b1; l_pre = 1'b1;
         e_start = 1'b0; e_stop = 1'b0; e_pre = 1'b0;
      end else begin
         bit mtick;
         mtick = (m_state == 1) && !e_start && !e_stop && (m_presc == TICK_CYC - 1);
         if (e_pre) begin
            m_q = '{7, 7, 7};
            m_pre_cnt++;
         end else if (mtick) begin
            m_q[m_owner] = (m_q[m_owner] + 1) % 8;
         end
         if (e_stop) begin
            m_state = 0; m_owner = 0; m_dwell = 0; m_presc = 0;
         end else if (e_start) begin
            if (m_state == 0) begin
               m_state = 1; m_owner = 0; m_dwell = 0; m_presc = 0; m_ticks = 0;
            end else begin
               m_state = (m_state == 1) ? 2 : 1;
            end
         end else if (m_state == 1) begin
            m_presc = (m_presc + 1) % TICK_CYC;
            if (mtick) begin
               m_ticks++;
               if (m_dwell == DWELL_TICKS - 1) begin
                  m_dwell = 0;
                  m_owner = (m_owner + 1) % 3;
               end else begin
                  m_dwell++;
               end
            end
         end
         h_start = {h_start[DEB_CYC:0], btn_start};
         h_stop  = {h_stop[DEB_CYC:0], btn_stop};
         h_pre   = {h_pre[DEB_CYC:0], btn_preset};
         deb_step(h_start, l_start, l_start, e_start);
         deb_step(h_stop, l_stop, l_stop, e_stop);
         deb_step(h_pre, l_pre, l_pre, e_pre);
      end
   end

   logic [8:0]  exp_q;
   logic [20:0] exp_all, got_all;
   always_comb begin
      exp_q   = {3'(m_q[0]), 3'(m_q[1]), 3'(m_q[2])};
      exp_all = {exp_q, exp_q[5:0], (m_state == 0) ? 3'b000 : 3'(3'b100 >> m_owner),
                 2'(m_state), (m_state == 1)};
   end
   assign got_all = {q, q_copy, grp_en, state, led};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      for (int i = 0; i < 3; i++) @(negedge clk);
      checks++;
      if (got_all !== 21'd0) begin
         failures++;
         $display("FAIL reset_state: got %h want %h", got_all, 21'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (got_all !== exp_all || state !== 2'b00) begin
            failures++;
            $display("FAIL reset_release: got %h want %h", got_all, exp_all);
         end
      end
   endtask

   task automatic test_start();
      int rdy = 0;
      btn_start = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 10) btn_start = 1'b1;
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL start_cycle: got %h want %h", got_all, exp_all);
         end
         if (state === 2'b01 && rdy == 0) begin
            rdy = i;
            checks++;
            if (q !== 9'd0 || grp_en !== 3'b100 || led !== 1'b1) begin
               failures++;
               $display("FAIL start_entry: got q=%h grp=%b led=%b want q=000 grp=100 led=1", q, grp_en, led);
            end
         end
      end
      checks++;
      if (rdy == 0 || rdy > 6) begin
         failures++;
         $display("FAIL start_latency: got %0d cycles want 1..6", rdy);
      end
   endtask

   task automatic test_count();
      int n = 0;
      while (m_ticks < 12 && n < 200) begin
         @(negedge clk);
         n++;
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL count_cycle: got %h want %h", got_all, exp_all);
         end
      end
      checks++;
      if (q !== 9'o444 || grp_en !== 3'b100 || n >= 200) begin
         failures++;
         $display("FAIL count_12_ticks: got q=%o grp=%b cycles=%0d want q=444 grp=100", q, grp_en, n);
      end
   endtask

   task automatic test_pause();
      logic [8:0] saved;
      int own;
      int n = 0;
      while (!(m_state == 1 && m_dwell == 1) && n < 40) begin
         @(negedge clk);
         n++;
      end
      btn_start = 1'b0;
      n = 0;
      while (m_state != 2 && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 4) btn_start = 1'b1;
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL pause_enter: got %h want %h", got_all, exp_all);
         end
      end
      btn_start = 1'b1;
      saved = exp_q;
      own = m_owner;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checks++;
         if (q !== saved || state !== 2'b10 || led !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold: got q=%h st=%b led=%b want q=%h st=10 led=0", q, state, led, saved);
         end
      end
      btn_start = 1'b0;
      n = 0;
      while (m_state != 1 && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 4) btn_start = 1'b1;
      end
      btn_start = 1'b1;
      checks++;
      if (state !== 2'b01 || grp_en !== 3'(3'b100 >> own) || q !== saved) begin
         failures++;
         $display("FAIL pause_resume: got st=%b grp=%b q=%h want st=01 grp=%b q=%h",
                  state, grp_en, q, 3'(3'b100 >> own), saved);
      end
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL resume_cycle: got %h want %h", got_all, exp_all);
         end
      end
   endtask

   task automatic test_preset();
      int n = 0;
      int pre_prev, tk_prev;
      bit seen = 0;
      bit tick_done = 0;
      while (!(m_state == 1 && m_owner == 0 && m_dwell == 0 && m_presc == 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      btn_preset = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         pre_prev = m_pre_cnt;
         tk_prev = m_ticks;
         @(negedge clk);
         if (i == 4) btn_preset = 1'b1;
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL preset_cycle: got %h want %h", got_all, exp_all);
         end
         if (m_pre_cnt != pre_prev) begin
            seen = 1;
            checks++;
            if (q !== 9'h1FF || q_copy !== 6'h3F || grp_en !== 3'b010) begin
               failures++;
               $display("FAIL preset_apply: got q=%h copy=%h grp=%b want 1ff 3f 010", q, q_copy, grp_en);
            end
         end else if (seen && !tick_done && m_ticks != tk_prev) begin
            tick_done = 1;
            checks++;
            if (q !== 9'o707) begin
               failures++;
               $display("FAIL preset_wrap: got q=%o want 707", q);
            end
         end
      end
      checks++;
      if (!seen || !tick_done) begin
         failures++;
         $display("FAIL preset_seen: got seen=%0d tick=%0d want 1 1", seen, tick_done);
      end
   endtask

   task automatic test_stop();
      logic [8:0] saved = '0;
      bit stopped = 0;
      for (int len = 1; len <= 2; len++) begin
         btn_stop = 1'b0;
         for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == len) btn_stop = 1'b1;
            checks++;
            if (got_all !== exp_all || state !== 2'b01) begin
               failures++;
               $display("FAIL stop_glitch%0d: got %h want %h", len, got_all, exp_all);
            end
         end
      end
      btn_stop = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 6) btn_stop = 1'b1;
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL stop_cycle: got %h want %h", got_all, exp_all);
         end
         if (m_state == 0 && !stopped) begin
            stopped = 1;
            saved = exp_q;
         end
      end
      for (int i = 0; i < 10; i++) @(negedge clk);
      checks++;
      if (!stopped || state !== 2'b00 || grp_en !== 3'b000 || led !== 1'b0 || q !== saved) begin
         failures++;
         $display("FAIL stop_idle: got st=%b grp=%b led=%b q=%h want st=00 grp=000 led=0 q=%h",
                  state, grp_en, led, q, saved);
      end
   endtask

   task automatic test_random();
      int c_start = 0, c_stop = 0, c_pre = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL random_cycle%0d: got %h want %h", i, got_all, exp_all);
         end
         if (c_start > 0) c_start--; else if ($urandom_range(0, 29) == 0) c_start = $urandom_range(1, 8);
         if (c_stop > 0) c_stop--; else if ($urandom_range(0, 79) == 0) c_stop = $urandom_range(1, 8);
         if (c_pre > 0) c_pre--; else if ($urandom_range(0, 49) == 0) c_pre = $urandom_range(1, 8);
         btn_start  = (c_start == 0);
         btn_stop   = (c_stop == 0);
         btn_preset = (c_pre == 0);
      end
      btn_start = 1'b1; btn_stop = 1'b1; btn_preset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (got_all !== exp_all) begin
            failures++;
            $display("FAIL random_settle: got %h want %h", got_all, exp_all);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int a = 0; a < 3 && m_state != 1; a++) begin
         btn_start = 1'b0;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 4) btn_start = 1'b1;
         end
      end
      for (int i = 0; i < 7; i++) @(negedge clk);
      checks++;
      if (state !== 2'b01) begin
         failures++;
         $display("FAIL areset_pre: got st=%b want 01", state);
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (q !== 9'd0 || q_copy !== 6'd0 || state !== 2'b00 || grp_en !== 3'b000 || led !== 1'b0) begin
         failures++;
         $display("FAIL areset_immediate: got %h want 0", got_all);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if (got_all !== exp_all || state !== 2'b00) begin
            failures++;
            $display("FAIL areset_release: got %h want %h", got_all, exp_all);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_count();
      test_pause();
      test_preset();
      test_stop();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
